// File: rtl/gigabit_tx_fifo.sv
// Egress store-and-forward frame buffer toward one 1G MAC TX port.
// Frame data sits in a RAM ring; committed frames queue as {start, len}.
module gigabit_tx_fifo #(
  parameter int DEPTH         = 1024,
  parameter int META_DEPTH    = 32,
  parameter int MAX_FRAME_LEN = 1522
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_start,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic [2:0]               wr_bytes_valid,
  input  logic                     wr_commit,
  input  logic                     wr_drop,
  output logic                     wr_queued,
  output logic                     wr_dropped,
  output logic [$clog2(DEPTH):0]   free_words,
  input  logic                     tx_ready,
  output logic                     tx_frame_start,
  output logic                     tx_data_valid,
  output logic [31:0]              tx_data,
  output logic [2:0]               tx_bytes_valid,
  output logic                     tx_commit,
  output logic                     tx_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(META_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
  localparam logic [11:0]   MAXL    = 12'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_DONE
  } state_t;

  logic [31:0]      r_mem  [DEPTH];
  logic [AW+10:0]   r_meta [META_DEPTH];
  logic [31:0]      r_rdata;
  logic [AW-1:0]    r_wr_ptr, r_frame_ptr, r_rd_ptr;
  logic [11:0]      r_len;
  logic             r_ovf, r_active;
  logic [CW-1:0]    r_used, r_cur_words, r_tx_words;
  logic [10:0]      r_rem;
  logic [MW:0]      r_mwp, r_mrp;
  logic             r_queued, r_dropped;
  state_t           r_state, w_state_nxt;

  logic             w_wr_ok, w_room, w_fits, w_do_write;
  logic [11:0]      w_len_sum, w_len_nxt;
  logic             w_ovf_nxt;
  logic [CW-1:0]    w_cur_nxt, w_add, w_rel;
  logic [AW-1:0]    w_fptr_nxt;
  logic             w_meta_full, w_meta_empty;
  logic             w_commit, w_close, w_accept, w_reject;
  logic             w_pop;
  logic [AW+10:0]   w_meta_rd;
  logic [AW-1:0]    w_mstart;
  logic [10:0]      w_mlen;
  logic [11:0]      w_mlen_up;
  logic [CW-1:0]    w_mwords;

  assign w_wr_ok    = r_active && wr_en && !wr_start;
  assign w_room     = (r_used + r_cur_words) < DEPTH_W;
  assign w_len_sum  = r_len + {9'd0, wr_bytes_valid};
  assign w_fits     = w_len_sum <= MAXL;
  assign w_do_write = w_wr_ok && w_room && w_fits;
  assign w_len_nxt  = w_do_write ? w_len_sum : r_len;
  assign w_ovf_nxt  = r_ovf || (w_wr_ok && !w_do_write);
  assign w_cur_nxt  = r_cur_words + CW'(w_do_write);
  assign w_fptr_nxt = r_frame_ptr + AW'(w_do_write);

  assign w_meta_empty = (r_mwp == r_mrp);
  assign w_meta_full  = (r_mwp[MW] != r_mrp[MW]) &&
                        (r_mwp[MW-1:0] == r_mrp[MW-1:0]);

  // A commit sees the word written in the same cycle.
  assign w_commit = r_active && !wr_start && wr_commit;
  assign w_close  = r_active && !wr_start && (wr_commit || wr_drop);
  assign w_accept = w_commit && !w_ovf_nxt &&
                    (w_len_nxt != 12'd0) && !w_meta_full;
  assign w_reject = w_commit && !w_accept;

  assign w_pop     = (r_state == S_IDLE) && !w_meta_empty && tx_ready;
  assign w_meta_rd = r_meta[r_mrp[MW-1:0]];
  assign w_mstart  = w_meta_rd[AW+10:11];
  assign w_mlen    = w_meta_rd[10:0];
  assign w_mlen_up = ({1'b0, w_mlen} + 12'd3) >> 2;
  assign w_mwords  = CW'(w_mlen_up);

  assign w_add = w_accept ? w_cur_nxt : '0;
  assign w_rel = (r_state == S_DONE) ? r_tx_words : '0;

  assign wr_queued  = r_queued;
  assign wr_dropped = r_dropped;
  assign free_words = DEPTH_W - r_used;

  // Data RAM write port.
  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_frame_ptr] <= wr_data;
  end

  // Data RAM read port, one cycle latency.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[r_rd_ptr];
  end

  // Metadata RAM write port.
  always_ff @(posedge clk) begin
    if (w_accept) r_meta[r_mwp[MW-1:0]] <= {r_wr_ptr, w_len_nxt[10:0]};
  end

  // Write-side frame tracking, commit/rollback and space accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= 1'b0;
      r_wr_ptr    <= '0;
      r_frame_ptr <= '0;
      r_len       <= '0;
      r_ovf       <= 1'b0;
      r_cur_words <= '0;
      r_used      <= '0;
      r_mwp       <= '0;
      r_queued    <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_queued  <= w_accept;
      r_dropped <= w_reject;
      if (wr_start) begin
        r_active    <= 1'b1;
        r_frame_ptr <= r_wr_ptr;
        r_len       <= '0;
        r_ovf       <= 1'b0;
        r_cur_words <= '0;
      end else if (w_close) begin
        r_active    <= 1'b0;
        r_len       <= '0;
        r_ovf       <= 1'b0;
        r_cur_words <= '0;
        if (w_accept) r_wr_ptr <= w_fptr_nxt;
      end else begin
        r_frame_ptr <= w_fptr_nxt;
        r_len       <= w_len_nxt;
        r_ovf       <= w_ovf_nxt;
        r_cur_words <= w_cur_nxt;
      end
      r_used <= r_used + w_add - w_rel;
      if (w_accept) r_mwp <= r_mwp + 1'b1;
    end
  end

  // TX state register, read pointer and remaining byte count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_rem      <= '0;
      r_tx_words <= '0;
      r_mrp      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_rd_ptr   <= w_mstart;
        r_rem      <= w_mlen;
        r_tx_words <= w_mwords;
        r_mrp      <= r_mrp + 1'b1;
      end
      if (r_state == S_START || r_state == S_DATA)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_state == S_DATA)
        r_rem <= r_rem - 11'd4;
    end
  end

  // TX next state and outputs.
  always_comb begin
    w_state_nxt    = r_state;
    tx_frame_start = 1'b0;
    tx_data_valid  = 1'b0;
    tx_data        = '0;
    tx_bytes_valid = '0;
    tx_commit      = 1'b0;
    tx_sent        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = S_START;
      end
      S_START: begin
        tx_frame_start = 1'b1;
        w_state_nxt    = S_DATA;
      end
      S_DATA: begin
        tx_data_valid  = 1'b1;
        tx_data        = r_rdata;
        tx_bytes_valid = (r_rem >= 11'd4) ? 3'd4 : r_rem[2:0];
        if (r_rem <= 11'd4) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        tx_commit   = 1'b1;
        tx_sent     = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gigabit_tx_fifo.sv
// Directed bench for gigabit_tx_fifo.
// Expected words are recorded as they are written.
module tb_gigabit_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_start, wr_en, wr_commit, wr_drop;
  logic [31:0] wr_data;
  logic [2:0]  wr_bytes_valid;
  logic        wr_queued, wr_dropped;
  logic [10:0] free_words;
  logic        tx_ready, w_tx_ready;
  logic        tx_frame_start, tx_data_valid, tx_commit, tx_sent;
  logic [31:0] tx_data;
  logic [2:0]  tx_bytes_valid;

  bit          rand_rdy = 1'b0;
  logic        r_rnd = 1'b0;

  int total = 0;
  int passed = 0;
  int n_commit = 0, n_sent = 0, n_fs = 0;
  int n_q = 0, n_drop = 0, n_coinc = 0;

  logic [31:0] exp_d[$];
  logic [2:0]  exp_b[$];
  logic [31:0] obs_d[$];
  logic [2:0]  obs_b[$];

  always #5 clk = ~clk;

  assign w_tx_ready = rand_rdy ? r_rnd : tx_ready;

  gigabit_tx_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .wr_start       (wr_start),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_bytes_valid (wr_bytes_valid),
    .wr_commit      (wr_commit),
    .wr_drop        (wr_drop),
    .wr_queued      (wr_queued),
    .wr_dropped     (wr_dropped),
    .free_words     (free_words),
    .tx_ready       (w_tx_ready),
    .tx_frame_start (tx_frame_start),
    .tx_data_valid  (tx_data_valid),
    .tx_data        (tx_data),
    .tx_bytes_valid (tx_bytes_valid),
    .tx_commit      (tx_commit),
    .tx_sent        (tx_sent)
  );

  always @(posedge clk) begin
    #1 r_rnd = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (tx_data_valid) begin
      obs_d.push_back(tx_data);
      obs_b.push_back(tx_bytes_valid);
    end
    if (tx_commit) n_commit++;
    if (tx_sent) n_sent++;
    if (tx_frame_start) n_fs++;
    if (wr_queued) n_q++;
    if (wr_dropped) n_drop++;
    if (wr_commit && tx_commit) n_coinc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_d.delete();
    exp_b.delete();
    obs_d.delete();
    obs_b.delete();
  endtask

  function automatic int data_errs();
    int e = 0;
    if (obs_d.size() != exp_d.size()) return 1000000;
    foreach (exp_d[i]) begin
      if (obs_d[i] !== exp_d[i]) e++;
      if (obs_b[i] !== exp_b[i]) e++;
    end
    return e;
  endfunction

  task automatic write_frame(input int len, input bit ok,
                             input bit do_commit);
    int w;
    logic [2:0] bv;
    w = (len + 3) / 4;
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    for (int i = 0; i < w; i++) begin
      bv = 3'd4;
      if (i == w - 1 && (len % 4) != 0) bv = 3'(len % 4);
      wr_en          = 1'b1;
      wr_data        = $urandom;
      wr_bytes_valid = bv;
      wr_commit      = do_commit && (i == w - 1);
      if (ok) begin
        exp_d.push_back(wr_data);
        exp_b.push_back(bv);
      end
      tick();
    end
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    if (w == 0 && do_commit) begin
      wr_commit = 1'b1;
      tick();
      wr_commit = 1'b0;
    end
  endtask

  task automatic wait_commits(input int target, input int budget);
    int c = 0;
    while (n_commit < target && c < budget) begin
      tick();
      c++;
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({wr_queued, wr_dropped, tx_frame_start, tx_data_valid,
         tx_data, tx_bytes_valid, tx_commit, tx_sent} !== '0) begin
      $display("FAIL reset_outputs: got %h %h %h %h %h %h %h %h want 0",
               wr_queued, wr_dropped, tx_frame_start, tx_data_valid,
               tx_data, tx_bytes_valid, tx_commit, tx_sent);
    end else passed++;
    total++;
    if (free_words !== 11'd1024)
      $display("FAIL reset_free: got %0d want 1024", free_words);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame64();
    int fs0, e;
    clear_q();
    fs0 = n_fs;
    tx_ready = 1'b1;
    write_frame(64, 1, 1);
    total++;
    if (wr_queued !== 1'b1)
      $display("FAIL f64_queued: got %b want 1", wr_queued);
    else passed++;
    total++;
    if (free_words !== 11'd1008)
      $display("FAIL f64_free_mid: got %0d want 1008", free_words);
    else passed++;
    wait_commits(n_commit + 1, 200);
    total++;
    if (n_fs - fs0 !== 1)
      $display("FAIL f64_start: got %0d want 1", n_fs - fs0);
    else passed++;
    e = data_errs();
    total++;
    if (e != 0) $display("FAIL f64_data: got %0d errors want 0", e);
    else passed++;
    total++;
    if (obs_b.size() != 16 || obs_b[15] !== 3'd4)
      $display("FAIL f64_last_bv: got %0d words want 16 with bv 4",
               obs_b.size());
    else passed++;
    total++;
    if (free_words !== 11'd1024)
      $display("FAIL f64_free_end: got %0d want 1024", free_words);
    else passed++;
  endtask

  task automatic test_frame61();
    int s0, e;
    clear_q();
    s0 = n_sent;
    tx_ready = 1'b1;
    write_frame(61, 1, 1);
    wait_commits(n_commit + 1, 200);
    e = data_errs();
    total++;
    if (e != 0) $display("FAIL f61_data: got %0d errors want 0", e);
    else passed++;
    total++;
    if (obs_b.size() != 16 || obs_b[15] !== 3'd1)
      $display("FAIL f61_last_bv: got %0d words want 16 with bv 1",
               obs_b.size());
    else passed++;
    total++;
    if (n_sent - s0 !== 1)
      $display("FAIL f61_sent: got %0d want 1", n_sent - s0);
    else passed++;
  endtask

  task automatic test_boundaries();
    int q0, d0, e;
    clear_q();
    tx_ready = 1'b0;
    q0 = n_q;
    d0 = n_drop;
    write_frame(1522, 1, 1);
    write_frame(1524, 0, 1);
    write_frame(0, 0, 1);
    write_frame(40, 0, 0);
    wr_drop = 1'b1;
    tick();
    wr_drop = 1'b0;
    wr_en = 1'b1;
    wr_bytes_valid = 3'd4;
    tick();
    wr_commit = 1'b1;
    tick();
    wr_en = 1'b0;
    wr_commit = 1'b0;
    repeat (2) tick();
    total++;
    if (n_q - q0 !== 1)
      $display("FAIL bnd_queued: got %0d want 1", n_q - q0);
    else passed++;
    total++;
    if (n_drop - d0 !== 2)
      $display("FAIL bnd_dropped: got %0d want 2", n_drop - d0);
    else passed++;
    total++;
    if (free_words !== 11'd643)
      $display("FAIL bnd_free: got %0d want 643", free_words);
    else passed++;
    tx_ready = 1'b1;
    wait_commits(n_commit + 1, 1000);
    e = data_errs();
    total++;
    if (e != 0) $display("FAIL bnd_data: got %0d errors want 0", e);
    else passed++;
    total++;
    if (obs_b.size() != 381 || obs_b[380] !== 3'd2)
      $display("FAIL bnd_last_bv: got %0d words want 381 with bv 2",
               obs_b.size());
    else passed++;
  endtask

  task automatic test_fill();
    int q0, d0, c0, e;
    clear_q();
    tx_ready = 1'b0;
    q0 = n_q;
    d0 = n_drop;
    write_frame(1520, 1, 1);
    write_frame(1520, 1, 1);
    write_frame(1056, 1, 1);
    tick();
    total++;
    if (free_words !== 11'd0)
      $display("FAIL fill_free: got %0d want 0", free_words);
    else passed++;
    write_frame(400, 0, 1);
    tick();
    total++;
    if (n_q - q0 !== 3 || n_drop - d0 !== 1)
      $display("FAIL fill_pulses: got q=%0d d=%0d want q=3 d=1",
               n_q - q0, n_drop - d0);
    else passed++;
    total++;
    if (free_words !== 11'd0)
      $display("FAIL fill_free_after: got %0d want 0", free_words);
    else passed++;
    c0 = n_commit;
    tx_ready = 1'b1;
    wait_commits(c0 + 3, 3000);
    e = data_errs();
    total++;
    if (e != 0 || n_commit - c0 !== 3)
      $display("FAIL fill_data: got %0d errors %0d frames want 0 and 3",
               e, n_commit - c0);
    else passed++;
    total++;
    if (free_words !== 11'd1024)
      $display("FAIL fill_free_end: got %0d want 1024", free_words);
    else passed++;
  endtask

  task automatic test_meta_full();
    int q0, d0, c0, e;
    clear_q();
    tx_ready = 1'b0;
    q0 = n_q;
    d0 = n_drop;
    for (int i = 0; i < 33; i++) write_frame(64, i < 32, 1);
    tick();
    total++;
    if (n_q - q0 !== 32 || n_drop - d0 !== 1)
      $display("FAIL meta_pulses: got q=%0d d=%0d want q=32 d=1",
               n_q - q0, n_drop - d0);
    else passed++;
    total++;
    if (free_words !== 11'd512)
      $display("FAIL meta_free: got %0d want 512", free_words);
    else passed++;
    c0 = n_commit;
    tx_ready = 1'b1;
    wait_commits(c0 + 32, 4000);
    repeat (20) tick();
    e = data_errs();
    total++;
    if (e != 0 || n_commit - c0 !== 32)
      $display("FAIL meta_data: got %0d errors %0d frames want 0 and 32",
               e, n_commit - c0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int k0, c, e;
    clear_q();
    tx_ready = 1'b1;
    k0 = n_coinc;
    write_frame(16, 1, 1);
    write_frame(16, 1, 0);
    c = 0;
    while (!tx_commit && c < 100) begin
      tick();
      c++;
    end
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    total++;
    if (n_coinc - k0 !== 1)
      $display("FAIL b2b_coincide: got %0d want 1", n_coinc - k0);
    else passed++;
    total++;
    if (free_words !== 11'd1020)
      $display("FAIL b2b_free: got %0d want 1020", free_words);
    else passed++;
    wait_commits(n_commit + 1, 200);
    e = data_errs();
    total++;
    if (e != 0) $display("FAIL b2b_data: got %0d errors want 0", e);
    else passed++;
  endtask

  task automatic test_stream();
    int d0, c0, len, w, c, e, nf;
    clear_q();
    d0 = n_drop;
    c0 = n_commit;
    nf = 120;
    rand_rdy = 1'b1;
    for (int i = 0; i < nf; i++) begin
      len = $urandom_range(60, 400);
      w = (len + 3) / 4;
      c = 0;
      while ((free_words < 11'(w) || (n_q - n_commit) >= 32) && c < 5000) begin
        tick();
        c++;
      end
      write_frame(len, 1, 1);
    end
    wait_commits(c0 + nf, 20000);
    rand_rdy = 1'b0;
    e = data_errs();
    total++;
    if (e != 0 || n_commit - c0 !== nf)
      $display("FAIL stream_data: got %0d errors %0d frames want 0 and %0d",
               e, n_commit - c0, nf);
    else passed++;
    total++;
    if (n_drop - d0 !== 0)
      $display("FAIL stream_drops: got %0d want 0", n_drop - d0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int c, c0, e;
    clear_q();
    tx_ready = 1'b1;
    write_frame(64, 0, 1);
    c = 0;
    while (!tx_data_valid && c < 50) begin
      tick();
      c++;
    end
    repeat (2) tick();
    c0 = n_commit;
    rst = 1'b1;
    tick();
    total++;
    if ({wr_queued, wr_dropped, tx_frame_start, tx_data_valid,
         tx_data, tx_bytes_valid, tx_commit, tx_sent} !== '0)
      $display("FAIL rstmid_outputs: got dv=%b data=%h want 0",
               tx_data_valid, tx_data);
    else passed++;
    total++;
    if (free_words !== 11'd1024)
      $display("FAIL rstmid_free: got %0d want 1024", free_words);
    else passed++;
    rst = 1'b0;
    repeat (30) tick();
    total++;
    if (n_commit !== c0)
      $display("FAIL rstmid_commit: got %0d want %0d", n_commit, c0);
    else passed++;
    clear_q();
    write_frame(22, 1, 1);
    wait_commits(c0 + 1, 200);
    e = data_errs();
    total++;
    if (e != 0 || obs_b.size() != 6 || obs_b[5] !== 3'd2)
      $display("FAIL rstmid_after: got %0d errors %0d words want 0 and 6",
               e, obs_b.size());
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    wr_start = 1'b0;
    wr_en = 1'b0;
    wr_commit = 1'b0;
    wr_drop = 1'b0;
    wr_data = '0;
    wr_bytes_valid = '0;
    tx_ready = 1'b0;
    test_reset();
    test_frame64();
    test_frame61();
    test_boundaries();
    test_fill();
    test_meta_full();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
